// File: rtl/network_pkg.sv
// Shared types and default constants for the forward-pass sequencer.
package network_pkg;

  localparam int unsigned DEF_N_LAYERS = 3;
  localparam int unsigned DEF_W_CNT    = 32;
  localparam int unsigned DEF_TIMEOUT  = 4096;
  localparam int unsigned OVR_W        = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLK_LSB   = 3'd1,
    RST_CONV  = 3'd2,
    WAIT_CONV = 3'd3,
    CLK_CACHE = 3'd4,
    OUTPUT    = 3'd5
  } seq_state_t;

  // Width of a layer index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_edge_sync.sv
// Brings the asynchronous sample strobe into clk and emits a one-cycle start
// pulse per rising edge.
module sample_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sample_clk,
  output logic start
);

  logic       sync0;
  logic       sync1;
  logic       sync1_d;
  logic [1:0] settle;

  // settle masks the refill of the synchronizer after rst, so a level that
  // went high during reset never produces a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      sync1_d <= 1'b0;
      settle  <= 2'd0;
      start   <= 1'b0;
    end else begin
      sync0   <= sample_clk;
      sync1   <= sync0;
      sync1_d <= sync1;
      if (settle != 2'd3) settle <= settle + 2'd1;
      start   <= sync1 & ~sync1_d & (settle == 2'd3);
    end
  end

endmodule

// File: rtl/forward_pass_sequencer.sv
// Sequences one forward pass through a chain of conv1d layers per sample
// strobe and keeps pass-length, overrun and timeout statistics.
module forward_pass_sequencer
  import network_pkg::*;
#(
  parameter int unsigned N_LAYERS = DEF_N_LAYERS,
  parameter int unsigned W_CNT    = DEF_W_CNT,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_clk,
  input  logic [N_LAYERS-1:0]                conv_out_v,
  input  logic                               clear_stats,
  output logic                               lsb_clk,
  output logic [N_LAYERS-1:0]                conv_rst,
  output logic [N_LAYERS-2:0]                ac_clk,
  output logic                               out_latch,
  output logic                               busy,
  output logic [W_CNT-1:0]                   pass_cycles,
  output logic [W_CNT-1:0]                   max_pass_cycles,
  output logic [OVR_W-1:0]                   overrun_cnt,
  output logic                               timeout_err,
  output logic [idx_width(N_LAYERS)-1:0]     err_layer
);

  localparam int unsigned KW = idx_width(N_LAYERS);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [N_LAYERS-1:0] ONE_RST = N_LAYERS'(1);
  localparam logic [N_LAYERS-2:0] ONE_AC  = (N_LAYERS-1)'(1);

  seq_state_t      state;
  seq_state_t      state_nx;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_nx;
  logic [TW-1:0]   wait_cnt;
  logic [W_CNT-1:0] cyc_cnt;
  logic            start;
  logic            timeout_hit;

  sample_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .start      (start)
  );

  // Next-state logic; out_v is only looked at while in WAIT_CONV.
  always_comb begin
    state_nx    = state;
    k_nx        = k;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = CLK_LSB;
          k_nx     = '0;
        end
      end
      CLK_LSB:  state_nx = RST_CONV;
      RST_CONV: state_nx = WAIT_CONV;
      WAIT_CONV: begin
        if (conv_out_v[k]) begin
          state_nx = (k == KW'(N_LAYERS - 1)) ? OUTPUT : CLK_CACHE;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          state_nx    = IDLE;
          timeout_hit = 1'b1;
        end
      end
      CLK_CACHE: begin
        state_nx = RST_CONV;
        k_nx     = k + KW'(1);
      end
      OUTPUT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and strobes; strobes are decoded from the next state so
  // each one is high exactly during its own state cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      wait_cnt  <= '0;
      cyc_cnt   <= '0;
      lsb_clk   <= 1'b0;
      conv_rst  <= '0;
      ac_clk    <= '0;
      out_latch <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_nx;
      k        <= k_nx;
      wait_cnt <= (state == WAIT_CONV) ? wait_cnt + TW'(1) : '0;
      if (state_nx == CLK_LSB) begin
        cyc_cnt <= W_CNT'(1);
      end else if ((state != IDLE) && (cyc_cnt != '1)) begin
        cyc_cnt <= cyc_cnt + W_CNT'(1);
      end
      lsb_clk   <= (state_nx == CLK_LSB);
      conv_rst  <= (state_nx == RST_CONV)  ? (ONE_RST << k_nx) : '0;
      ac_clk    <= (state_nx == CLK_CACHE) ? (ONE_AC << k_nx)  : '0;
      out_latch <= (state_nx == OUTPUT);
      busy      <= (state_nx != IDLE);
    end
  end

  // Statistics; a clear pulse takes priority over any same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cycles     <= '0;
      max_pass_cycles <= '0;
      overrun_cnt     <= '0;
      timeout_err     <= 1'b0;
      err_layer       <= '0;
    end else begin
      if (state == OUTPUT) pass_cycles <= cyc_cnt;
      if (clear_stats) begin
        max_pass_cycles <= '0;
        overrun_cnt     <= '0;
        timeout_err     <= 1'b0;
        err_layer       <= '0;
      end else begin
        if ((state == OUTPUT) && (cyc_cnt > max_pass_cycles)) begin
          max_pass_cycles <= cyc_cnt;
        end
        if (start && (state != IDLE) && (overrun_cnt != '1)) begin
          overrun_cnt <= overrun_cnt + OVR_W'(1);
        end
        if (timeout_hit) begin
          timeout_err <= 1'b1;
          err_layer   <= k;
        end
      end
    end
  end

endmodule

// File: doc/forward_pass_sequencer.md
FORWARD_PASS_SEQUENCER -- requirements
Module: forward_pass_sequencer

Interface
REQ-001 Parameter N_LAYERS, default 3, number of conv1d layers sequenced (range 2-8).
REQ-002 Parameter W_CNT, default 32, width of cycle counters.
REQ-003 Parameter TIMEOUT, default 4096, maximum clk cycles allowed waiting for one layer's out_v.
REQ-004 Port clk  input  1  single clock; all logic on posedge clk.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port sample_clk  input  1  asynchronous sample-rate strobe; each rising edge requests one forward pass.
REQ-007 Port conv_out_v  input  N_LAYERS  bit k = out_v of conv layer k.
REQ-008 Port clear_stats  input  1  one-cycle pulse clearing statistics and sticky flags.
REQ-009 Port lsb_clk  output  1  one-cycle strobe to the input left-shift buffers.
REQ-010 Port conv_rst  output  N_LAYERS  bit k = one-cycle reset/start strobe to conv layer k.
REQ-011 Port ac_clk  output  N_LAYERS-1  bit k = one-cycle strobe to the activation cache after layer k.
REQ-012 Port out_latch  output  1  one-cycle strobe capturing final layer output.
REQ-013 Port busy  output  1  high whenever state is not IDLE.
REQ-014 Port pass_cycles  output  W_CNT  length of last completed pass.
REQ-015 Port max_pass_cycles  output  W_CNT  longest completed pass since reset/clear.
REQ-016 Port overrun_cnt  output  16  sample_clk edges dropped while busy, saturating.
REQ-017 Port timeout_err  output  1  sticky: a layer timed out.
REQ-018 Port err_layer  output  max(1,$clog2(N_LAYERS))  index of layer that last timed out.

Function
REQ-019 sample_clk SHALL pass a 2-flop synchronizer; a registered rising-edge pulse (start) SHALL assert 3 clk cycles after the edge is first sampled.
REQ-020 States SHALL be IDLE, CLK_LSB, RST_CONV, WAIT_CONV, CLK_CACHE, OUTPUT; layer index k held in a register.
REQ-021 IDLE: start -> CLK_LSB, k=0; otherwise stay.
REQ-022 CLK_LSB: lsb_clk=1 this cycle only -> RST_CONV.
REQ-023 RST_CONV: conv_rst[k]=1 this cycle only, wait counter cleared -> WAIT_CONV.
REQ-024 WAIT_CONV: conv_out_v[k] SHALL be ignored during RST_CONV and sampled from the first WAIT_CONV cycle; on conv_out_v[k]=1 -> CLK_CACHE if k<N_LAYERS-1, else OUTPUT.
REQ-025 CLK_CACHE: ac_clk[k]=1 this cycle only, k<=k+1 -> RST_CONV.
REQ-026 OUTPUT: out_latch=1 this cycle only; pass_cycles and max_pass_cycles updated; -> IDLE.
REQ-027 pass_cycles SHALL count cycles from CLK_LSB through OUTPUT inclusive; with out_v in the first WAIT_CONV cycle and N_LAYERS=3 the value SHALL be 10.
REQ-028 Timeout: if WAIT_CONV persists TIMEOUT cycles without out_v, SHALL set timeout_err, load err_layer=k, return to IDLE without out_latch or stats update.
REQ-029 start while busy SHALL NOT restart or perturb the pass; overrun_cnt SHALL increment, saturating at 16'hFFFF.
REQ-030 At most one strobe output (lsb_clk, conv_rst, ac_clk, out_latch) SHALL be high in any cycle.
REQ-031 clear_stats SHALL zero max_pass_cycles, overrun_cnt, timeout_err, err_layer next cycle without affecting an in-flight pass; clear simultaneous with overrun or timeout: clear wins.
REQ-032 pass_cycles/max_pass_cycles counters SHALL saturate at all-ones.

Reset
REQ-033 rst SHALL force IDLE, k=0, synchronizer flops 0, all strobes 0, busy 0, all statistics and flags 0, next cycle; rst mid-pass SHALL abandon the pass with no further strobes.
REQ-034 A sample_clk edge during rst SHALL be discarded.

Structure
REQ-035 State enum and default parameter constants SHALL live in shared package network_pkg.
REQ-036 Synchronizer plus edge detect SHALL be sub-module sample_edge_sync.

Verification
REQ-037 N_LAYERS=3, every out_v returned 1 cycle after its conv_rst -> strobe order lsb_clk, conv_rst[0], ac_clk[0], conv_rst[1], ac_clk[1], conv_rst[2], out_latch; pass_cycles=10.
REQ-038 out_v delays 5,20,7 cycles -> pass_cycles=39, max_pass_cycles=39; then a 10-cycle pass -> max stays 39.
REQ-039 Second sample_clk edge mid-pass -> overrun_cnt=1, pass completes unchanged, single out_latch.
REQ-040 TIMEOUT=16, conv_out_v[1] never asserted -> timeout_err=1, err_layer=1, no out_latch, busy low; next edge runs a normal pass.
REQ-041 rst asserted in WAIT_CONV of layer 2 -> all outputs 0 next cycle, no out_latch; clear_stats coincident with an overrun -> overrun_cnt=0.
